// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV64 funct3 codes, FSM state, lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Byte-strobe pattern for an access size, before shifting to its lane.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed lanes of a returned doubleword to bit 0 and sign/zero-extends per funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] shifted;
  logic        is_unsigned;

  assign shifted     = rdata >> {offset, 3'b000};
  assign is_unsigned = funct3[2];

  always_comb begin
    data = shifted;
    case (funct3[1:0])
      2'b00: data = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01: data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10: data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding RV64 load/store unit. Define LSU_MISALIGN_TRAP_EN to fault misaligned
// accesses; otherwise they are issued and lanes beyond the doubleword are dropped.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_fault
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the valid side holds its payload stable until that edge.

  state_t            state, state_next;
  logic [XLEN-1:0]   addr_q, wdata_q, load_data;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic              bad_enc, misalign, fault;
  logic              accept, store_out;
  logic [7:0]        strb;

  assign bad_enc = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = |(req_addr[2:0] & align_mask(req_funct3[1:0]));
`else
  assign misalign = 1'b0;
`endif
  assign fault  = bad_enc | misalign;
  assign accept = req_ready & req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid)     state_next = fault ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_req_ready) state_next = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem_rvalid)    state_next = ST_RESP;
      ST_RESP: if (resp_ready)    state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = rst_n & (state == ST_IDLE);
    mem_req_valid = (state == ST_REQ);
    resp_valid    = (state == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      resp_data  <= '0;
      resp_fault <= 1'b0;
    end else if (accept) begin
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      we_q       <= req_we;
      funct3_q   <= req_funct3;
      resp_data  <= '0;
      resp_fault <= fault;
    end else if (state == ST_WAIT && mem_rvalid) begin
      resp_data  <= load_data;
    end
  end

  lsu_load_align u_align (
    .rdata  (mem_rdata),
    .offset (addr_q[2:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Strobes shifted past lane 7 fall off the 8-bit vector, which drops out-of-doubleword bytes.
  assign strb      = size_mask(funct3_q[1:0]) << addr_q[2:0];
  assign store_out = mem_req_valid & we_q;
  assign mem_addr  = mem_req_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_we    = store_out;
  assign mem_wstrb = store_out ? strb : 8'h00;
  assign mem_wdata = store_out ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, faults, backpressure and mid-transaction reset.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        resp_valid, resp_ready, resp_fault;
  logic [63:0] resp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_fault(resp_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [63:0] a, input logic we, input logic [2:0] f3,
                           input logic [63:0] wd);
    req_valid  = 1'b1;
    req_addr   = a;
    req_we     = we;
    req_funct3 = f3;
    req_wdata  = wd;
  endtask

  task automatic run_load(input string tag, input logic [63:0] a, input logic [2:0] f3,
                          input logic [63:0] rd, input logic [63:0] exp);
    @(negedge clk);
    drive_req(a, 1'b0, f3, 64'd0);
    mem_req_ready = 1'b1;
    chk({tag, ".req_ready"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".mem_req_valid"}, mem_req_valid, 1'b1);
    chk({tag, ".mem_addr"}, mem_addr, {a[63:3], 3'b000});
    chk({tag, ".mem_wstrb"}, mem_wstrb, 8'h00);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    chk({tag, ".resp_valid_c2"}, resp_valid, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 64'd0;
    chk({tag, ".resp_valid_c3"}, resp_valid, 1'b1);
    chk({tag, ".resp_data"}, resp_data, exp);
    chk({tag, ".resp_fault"}, resp_fault, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".idle"}, {resp_valid, req_ready}, 2'b01);
  endtask

  task automatic run_store(input string tag, input logic [63:0] a, input logic [2:0] f3,
                           input logic [63:0] wd, input logic [7:0] exp_strb,
                           input logic [63:0] exp_wdata);
    @(negedge clk);
    drive_req(a, 1'b1, f3, wd);
    mem_req_ready = 1'b1;
    chk({tag, ".req_ready"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".mem_req_valid"}, mem_req_valid, 1'b1);
    chk({tag, ".mem_we"}, mem_we, 1'b1);
    chk({tag, ".mem_addr"}, mem_addr, {a[63:3], 3'b000});
    chk({tag, ".mem_wstrb"}, mem_wstrb, exp_strb);
    chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    chk({tag, ".resp_valid_c1"}, resp_valid, 1'b0);
    @(negedge clk);
    chk({tag, ".resp_valid_c2"}, resp_valid, 1'b1);
    chk({tag, ".resp_fault"}, resp_fault, 1'b0);
    chk({tag, ".resp_data"}, resp_data, 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".idle"}, {resp_valid, req_ready}, 2'b01);
  endtask

  task automatic run_fault(input string tag, input logic [63:0] a, input logic we,
                           input logic [2:0] f3);
    @(negedge clk);
    drive_req(a, we, f3, 64'hFFFF_FFFF_FFFF_FFFF);
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".mem_req_valid"}, mem_req_valid, 1'b0);
    chk({tag, ".resp_valid"}, resp_valid, 1'b1);
    chk({tag, ".resp_fault"}, resp_fault, 1'b1);
    chk({tag, ".resp_data"}, resp_data, 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".mem_req_valid2"}, mem_req_valid, 1'b0);
    chk({tag, ".idle"}, {resp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_funct3 = 3'b000;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.req_ready", req_ready, 1'b0);
    chk("rst.mem_req_valid", mem_req_valid, 1'b0);
    chk("rst.mem_fields", {mem_we, mem_wstrb, mem_addr, mem_wdata}, '0);
    chk("rst.resp", {resp_valid, resp_fault}, 2'b00);
    chk("rst.resp_data", resp_data, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.req_ready_after", req_ready, 1'b1);

    // Loads
    run_load("lb_1003",  64'h1003, F3_B,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    run_load("lwu_2004", 64'h2004, F3_WU, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
    run_load("lw_2004",  64'h2004, F3_W,  64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
    run_load("lh_0016",  64'h0016, F3_H,  64'h1122_3344_5566_8899, 64'h0000_0000_0000_1122);
    run_load("lhu_0010", 64'h0010, F3_HU, 64'h1122_3344_5566_8899, 64'h0000_0000_0000_8899);
    run_load("lh_0010",  64'h0010, F3_H,  64'h1122_3344_5566_8899, 64'hFFFF_FFFF_FFFF_8899);
    run_load("lbu_0017", 64'h0017, F3_BU, 64'h9122_3344_5566_8899, 64'h0000_0000_0000_0091);
    run_load("ld_5000",  64'h5000, F3_D,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // Stores
    run_store("sh_3006", 64'h3006, F3_H, 64'h0000_0000_0000_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000);
    run_store("sb_3001", 64'h3001, F3_B, 64'h0000_0000_0000_00AA, 8'h02, 64'h0000_0000_0000_AA00);
    run_store("sd_3008", 64'h3008, F3_D, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    run_fault("sw_4002_trap", 64'h4002, 1'b1, F3_W);
`else
    run_store("sw_4002", 64'h4002, F3_W, 64'h0000_0000_DEAD_BEEF, 8'h3C, 64'h0000_DEAD_BEEF_0000);
`endif

    // Unsupported encodings
    run_fault("load_f3_111", 64'h0100, 1'b0, 3'b111);
    run_fault("store_f3_100", 64'h0108, 1'b1, 3'b100);

    // Backpressure on both sides: payloads hold and no new access is taken
    @(negedge clk);
    drive_req(64'h4010, 1'b0, F3_D, 64'd0);
    mem_req_ready = 1'b0;
    chk("stall.req_ready", req_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("stall.mem_req_valid", mem_req_valid, 1'b1);
      chk("stall.mem_addr", mem_addr, 64'h4010);
      chk("stall.mem_we_strb", {mem_we, mem_wstrb}, 9'd0);
      chk("stall.req_ready_busy", req_ready, 1'b0);
    end
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b1;
    mem_rdata     = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    chk("stall.wait_resp_valid", resp_valid, 1'b0);
    chk("stall.wait_mem_req_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 64'd0; mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall.resp_valid", resp_valid, 1'b1);
      chk("stall.resp_data", resp_data, 64'hCAFE_F00D_1234_5678);
      chk("stall.resp_fault", resp_fault, 1'b0);
      chk("stall.req_ready_resp", req_ready, 1'b0);
      @(negedge clk);
    end
    chk("stall.resp_valid_last", resp_valid, 1'b1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("stall.idle", {resp_valid, req_ready}, 2'b01);

    // Reset while waiting for load data, then a stray return
    @(negedge clk);
    drive_req(64'h6000, 1'b0, F3_D, 64'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw.mem_req_valid", mem_req_valid, 1'b1);
    @(negedge clk);
    chk("rstw.in_wait", {mem_req_valid, resp_valid, req_ready}, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("rstw.req_ready_low", req_ready, 1'b0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 64'd0;
    chk("rstw.resp_valid", resp_valid, 1'b0);
    chk("rstw.req_ready", req_ready, 1'b1);
    chk("rstw.resp_data", resp_data, 64'd0);
    run_load("ld_after_rst", 64'h6008, F3_D, 64'h0F1E_2D3C_4B5A_6978, 64'h0F1E_2D3C_4B5A_6978);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
